// File: rtl/aer_pkg.sv
// Shared AER link definitions used by both the encoder and decoder sides:
// address width, the reserved null (end-of-frame) code and handshake states.
package aer_pkg;

    localparam int AER_ADDR_WIDTH = 4;
    localparam logic [AER_ADDR_WIDTH-1:0] AER_NULL_ADDR = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } aer_hs_state_t;

endpackage

// File: rtl/aer_handshake_rx.sv
// Receiver side of the four-phase req/ack handshake: acknowledges each request
// and emits a one-cycle accept strobe on the edge where the request is taken.
module aer_handshake_rx
    import aer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic aer_req,
    output logic aer_ack,
    output logic accept
);

    aer_hs_state_t state_r;
    aer_hs_state_t state_s;

    // State register; ack is decoded straight from it so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and accept strobe; a request is only taken from IDLE.
    always_comb begin
        state_s = state_r;
        accept  = 1'b0;
        case (state_r)
            IDLE: begin
                if (aer_req) begin
                    state_s = ACK;
                    accept  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK: begin
                if (!aer_req) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign aer_ack = (state_r == ACK);

endmodule

// File: rtl/aer_decoder.sv
// AER receiver: accumulates event addresses into a spike vector and publishes it
// on each null address. Optional duplicate detection: AER_DECODER_DUP_CHECK_EN.
module aer_decoder
    import aer_pkg::*;
#(
    parameter int VECTOR_WIDTH = 5,
    parameter int ADDR_WIDTH   = AER_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   aer_addr,
    input  logic                    aer_req,
    output logic                    aer_ack,
    output logic [VECTOR_WIDTH-1:0] spike_out,
    output logic                    spike_valid,
    output logic                    range_err,
    output logic                    dup_err
);

    localparam logic [ADDR_WIDTH-1:0]   NULL_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [VECTOR_WIDTH-1:0] LSB_ONE   = {{(VECTOR_WIDTH-1){1'b0}}, 1'b1};

    logic                    accept_s;
    logic                    is_null_s;
    logic                    is_valid_s;
    logic [VECTOR_WIDTH-1:0] hit_mask_s;
    logic [VECTOR_WIDTH-1:0] acc_r;
    logic [VECTOR_WIDTH-1:0] spike_out_r;
    logic                    spike_valid_r;
    logic                    range_err_r;

    aer_handshake_rx u_hs (
        .clk     (clk),
        .reset   (reset),
        .aer_req (aer_req),
        .aer_ack (aer_ack),
        .accept  (accept_s)
    );

    // Classify the sampled address and build its one-hot bit in the vector.
    always_comb begin
        is_null_s  = (aer_addr == NULL_ADDR);
        is_valid_s = ({{(32-ADDR_WIDTH){1'b0}}, aer_addr} < 32'(VECTOR_WIDTH));
        if (is_valid_s) begin
            hit_mask_s = LSB_ONE << aer_addr;
        end else begin
            hit_mask_s = {VECTOR_WIDTH{1'b0}};
        end
    end

    // Accumulator, frame publication and sticky range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r         <= {VECTOR_WIDTH{1'b0}};
            spike_out_r   <= {VECTOR_WIDTH{1'b0}};
            spike_valid_r <= 1'b0;
            range_err_r   <= 1'b0;
        end else begin
            spike_valid_r <= 1'b0;
            if (accept_s) begin
                if (is_null_s) begin
                    spike_out_r   <= acc_r;
                    spike_valid_r <= 1'b1;
                    acc_r         <= {VECTOR_WIDTH{1'b0}};
                end else if (is_valid_s) begin
                    acc_r <= acc_r | hit_mask_s;
                end else begin
                    range_err_r <= 1'b1;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

`ifdef AER_DECODER_DUP_CHECK_EN
    logic dup_err_r;

    // Sticky flag for a valid address whose bit is already set in this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            dup_err_r <= 1'b0;
        end else if (accept_s && is_valid_s && (|(acc_r & hit_mask_s))) begin
            dup_err_r <= 1'b1;
        end else begin
            dup_err_r <= dup_err_r;
        end
    end

    assign dup_err = dup_err_r;
`else
    assign dup_err = 1'b0;
`endif

    assign spike_out   = spike_out_r;
    assign spike_valid = spike_valid_r;
    assign range_err   = range_err_r;

endmodule
